// File: rtl/capa_char_pkg.sv
// Shared types and constants for the capacitance-characterisation match search.
package capa_char_pkg;

    // Width of unsigned delay values in ps.
    localparam int unsigned TW = 24;
    // Width of a sample index within one sweep.
    localparam int unsigned IW = 7;

    typedef logic [TW-1:0] delay_t;
    typedef logic [IW-1:0] idx_t;
    // Sum of two TW-bit absolute differences never overflows TW+1 bits.
    typedef logic [TW:0]   err_t;

    typedef enum logic [1:0] {
        StIdle,
        StRun,
        StFlush,
        StDone
    } state_e;

    // "No match yet": any real error compares strictly below this.
    localparam err_t ERR_INIT = '1;

endpackage

// File: rtl/capa_match_search_if.sv
// Sweep stream, reference and result bundle between the sweep source and the search block.
interface capa_match_search_if;
    import capa_char_pkg::*;

    // Sweep control and reference pair
    logic   start;
    delay_t ref_rise;
    delay_t ref_fall;

    // Sample stream
    logic   in_valid;
    logic   in_ready;
    delay_t in_rise;
    delay_t in_fall;

    // Status and results
    logic   busy;
    logic   done;
    idx_t   best_idx;
    err_t   best_err;
    logic   cross_valid;
    idx_t   cross_idx;
    logic   nonmono;

    modport master (
        output start,
        output ref_rise,
        output ref_fall,
        output in_valid,
        input  in_ready,
        output in_rise,
        output in_fall,
        input  busy,
        input  done,
        input  best_idx,
        input  best_err,
        input  cross_valid,
        input  cross_idx,
        input  nonmono
    );

    modport slave (
        input  start,
        input  ref_rise,
        input  ref_fall,
        input  in_valid,
        output in_ready,
        input  in_rise,
        input  in_fall,
        output busy,
        output done,
        output best_idx,
        output best_err,
        output cross_valid,
        output cross_idx,
        output nonmono
    );

endinterface

// File: rtl/abs_diff.sv
// Combinational unsigned absolute difference |a - b| on delay-width operands.
module abs_diff
    import capa_char_pkg::*;
(
    input  delay_t a,
    input  delay_t b,
    output delay_t y
);

    // Subtract the smaller from the larger so the result never wraps.
    always_comb begin
        y = '0;
        if (a >= b) begin
            y = a - b;
        end else begin
            y = b - a;
        end
    end

endmodule

// File: rtl/capa_match_search.sv
// Scans one propagation-time sweep against a reference rise/fall pair and reports the
// best-matching capacitance index, the first rise crossing and a non-monotonic flag.
module capa_match_search
    import capa_char_pkg::*;
#(
    parameter int unsigned NBCAPA = 100
) (
    input  logic                clk,
    input  logic                rst,
    capa_match_search_if.slave  bus
);

    // Sweep control
    state_e state_q, state_d;
    idx_t   cnt_q;
    delay_t ref_rise_q, ref_fall_q;

    // Stage-1 sample register
    logic   s1_valid_q;
    idx_t   s1_idx_q;
    delay_t s1_rise_q, s1_fall_q;

    // Previous-sample history for crossing and monotonicity checks
    logic   prev_ge_q;
    delay_t prev_rise_q;

    // Results
    idx_t   best_idx_q;
    err_t   best_err_q;
    logic   cross_valid_q;
    idx_t   cross_idx_q;
    logic   nonmono_q;

    // Derived combinational signals
    logic   sweep_start;
    logic   accept;
    logic   last_sample;
    delay_t diff_rise, diff_fall;
    err_t   err;
    logic   ge;
    logic   first_sample;

    assign sweep_start  = (state_q == StIdle) && bus.start;
    assign accept       = (state_q == StRun) && bus.in_valid;
    assign last_sample  = (cnt_q == idx_t'(NBCAPA - 1));

    abs_diff u_abs_rise (
        .a (s1_rise_q),
        .b (ref_rise_q),
        .y (diff_rise)
    );

    abs_diff u_abs_fall (
        .a (s1_fall_q),
        .b (ref_fall_q),
        .y (diff_fall)
    );

    assign err          = err_t'(diff_rise) + err_t'(diff_fall);
    // A sample sitting exactly on the reference counts as "at or above".
    assign ge           = (s1_rise_q >= ref_rise_q);
    assign first_sample = (s1_idx_q == '0);

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic: RUN until the last index is accepted, one drain cycle, one done cycle
    always_comb begin
        state_d = state_q;
        case (state_q)
            StIdle: begin
                if (bus.start) begin
                    state_d = StRun;
                end
            end
            StRun: begin
                if (accept && last_sample) begin
                    state_d = StFlush;
                end
            end
            StFlush: begin
                state_d = StDone;
            end
            StDone: begin
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    // Status outputs decoded from the current state
    always_comb begin
        bus.in_ready = (state_q == StRun);
        bus.busy     = (state_q == StRun) || (state_q == StFlush);
        bus.done     = (state_q == StDone);
    end

    // Reference latch and sample counter; refs only move on a start seen in IDLE
    always_ff @(posedge clk) begin
        if (rst) begin
            ref_rise_q <= '0;
            ref_fall_q <= '0;
            cnt_q      <= '0;
        end else if (sweep_start) begin
            ref_rise_q <= bus.ref_rise;
            ref_fall_q <= bus.ref_fall;
            cnt_q      <= '0;
        end else if (accept) begin
            cnt_q      <= cnt_q + idx_t'(1);
        end
    end

    // Stage-1 register: capture each accepted sample together with its index
    always_ff @(posedge clk) begin
        if (rst) begin
            s1_valid_q <= 1'b0;
            s1_idx_q   <= '0;
            s1_rise_q  <= '0;
            s1_fall_q  <= '0;
        end else begin
            s1_valid_q <= accept;
            if (accept) begin
                s1_idx_q  <= cnt_q;
                s1_rise_q <= bus.in_rise;
                s1_fall_q <= bus.in_fall;
            end
        end
    end

    // Result update from stage 1; results hold from done until the next start
    always_ff @(posedge clk) begin
        if (rst || sweep_start) begin
            best_idx_q    <= '0;
            best_err_q    <= ERR_INIT;
            cross_valid_q <= 1'b0;
            cross_idx_q   <= '0;
            nonmono_q     <= 1'b0;
            prev_ge_q     <= 1'b0;
            prev_rise_q   <= '0;
        end else if (s1_valid_q) begin
            // Strict compare keeps the lowest index on ties.
            if (err < best_err_q) begin
                best_err_q <= err;
                best_idx_q <= s1_idx_q;
            end
            if (!first_sample) begin
                if ((ge != prev_ge_q) && !cross_valid_q) begin
                    cross_valid_q <= 1'b1;
                    cross_idx_q   <= s1_idx_q;
                end
                if (s1_rise_q < prev_rise_q) begin
                    nonmono_q <= 1'b1;
                end
            end
            prev_ge_q   <= ge;
            prev_rise_q <= s1_rise_q;
        end
    end

    // Result outputs
    always_comb begin
        bus.best_idx    = best_idx_q;
        bus.best_err    = best_err_q;
        bus.cross_valid = cross_valid_q;
        bus.cross_idx   = cross_idx_q;
        bus.nonmono     = nonmono_q;
    end

endmodule

// File: tb/tb_capa_match_search.sv
// Directed, table-driven bench for capa_match_search with a 100-sample sweep.
module tb_capa_match_search;
    import capa_char_pkg::*;

    localparam int NB = 100;

    typedef struct {
        int pat;
        int rr;
        int rf;
        bit gappy;
        bit inject;
        int e_idx;
        int e_err;
        bit e_cv;
        int e_ci;
        bit e_nm;
    } vec_t;

    logic clk = 1'b0;
    logic rst;
    int   n_vec = 0;
    int   n_bad = 0;

    always #5 clk = ~clk;

    capa_match_search_if bus ();

    capa_match_search #(
        .NBCAPA (NB)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    // Sample patterns; each covers a full 100-entry sweep.
    function automatic void sample(input int pat, input int k, output delay_t r, output delay_t f);
        r = '0;
        f = '0;
        case (pat)
            0: begin
                r = delay_t'(4900 + 10 * k);
                f = delay_t'(4700 + 10 * k);
            end
            1: begin
                if (k == 0)      r = delay_t'(990);
                else if (k < 3)  r = delay_t'(1010);
                else             r = delay_t'(1020 + 10 * (k - 3));
                f = delay_t'(1000);
            end
            2: begin
                r = (k == 5) ? delay_t'(150) : delay_t'(200 + k);
                f = delay_t'(100);
            end
            default: begin
                r = delay_t'(4000 + 15 * k);
                f = delay_t'(6000 - 12 * k);
            end
        endcase
    endfunction

    task automatic check_reset_values(input string tag);
        check({tag, " in_ready"}, 64'(bus.in_ready), 64'd0);
        check({tag, " busy"}, 64'(bus.busy), 64'd0);
        check({tag, " done"}, 64'(bus.done), 64'd0);
        check({tag, " best_idx"}, 64'(bus.best_idx), 64'd0);
        check({tag, " best_err"}, 64'(bus.best_err), 64'd33554431);
        check({tag, " cross_valid"}, 64'(bus.cross_valid), 64'd0);
        check({tag, " cross_idx"}, 64'(bus.cross_idx), 64'd0);
        check({tag, " nonmono"}, 64'(bus.nonmono), 64'd0);
    endtask

    // Called #1 after a posedge with the DUT in IDLE; returns #1 after the posedge
    // following done, i.e. in the cycle where a back-to-back start is legal.
    task automatic run_sweep(input string tag, input vec_t v);
        int     k;
        int     cyc;
        int     lat;
        bit     injected;
        delay_t r, f;
        k        = 0;
        cyc      = 0;
        injected = 1'b0;
        bus.start    = 1'b1;
        bus.ref_rise = delay_t'(v.rr);
        bus.ref_fall = delay_t'(v.rf);
        @(posedge clk); #1;
        bus.start = 1'b0;
        check({tag, " busy in run"}, 64'(bus.busy), 64'd1);
        while (k < NB && cyc < 1000) begin
            sample(v.pat, k, r, f);
            bus.in_rise  = r;
            bus.in_fall  = f;
            bus.in_valid = v.gappy ? 1'($urandom_range(0, 1)) : 1'b1;
            if (v.inject && k == 50 && !injected) begin
                bus.start    = 1'b1;
                bus.ref_rise = '0;
                bus.ref_fall = '0;
                injected     = 1'b1;
            end else begin
                bus.start = 1'b0;
            end
            @(negedge clk);
            if (bus.in_valid && bus.in_ready) k++;
            @(posedge clk); #1;
            cyc++;
        end
        bus.in_valid = 1'b0;
        bus.start    = 1'b0;
        check({tag, " accepts"}, 64'(k), 64'(NB));
        check({tag, " in_ready after last"}, 64'(bus.in_ready), 64'd0);
        lat = 1;
        while (!bus.done && lat < 20) begin
            @(posedge clk); #1;
            lat++;
        end
        check({tag, " done latency"}, 64'(lat), 64'd2);
        check({tag, " best_idx"}, 64'(bus.best_idx), 64'(v.e_idx));
        check({tag, " best_err"}, 64'(bus.best_err), 64'(v.e_err));
        check({tag, " cross_valid"}, 64'(bus.cross_valid), 64'(v.e_cv));
        check({tag, " cross_idx"}, 64'(bus.cross_idx), 64'(v.e_ci));
        check({tag, " nonmono"}, 64'(bus.nonmono), 64'(v.e_nm));
        @(posedge clk); #1;
        check({tag, " done one cycle"}, 64'(bus.done), 64'd0);
        check({tag, " busy after done"}, 64'(bus.busy), 64'd0);
    endtask

    vec_t   vecs[6];
    vec_t   vr;
    int     k;
    delay_t r, f;
    bit     saw_done;

    initial begin
        //          pat  rr    rf    gap inj idx err cv ci  nm
        vecs[0] = '{0, 5000, 4800, 0,  0,  10, 0,  1, 10, 0};  // exact match
        vecs[1] = '{1, 1000, 1000, 0,  0,  0,  10, 1, 1,  0};  // tie, lowest index wins
        vecs[2] = '{2, 100,  100,  0,  0,  5,  50, 0, 0,  1};  // no crossing, dip at 5
        vecs[3] = '{3, 4600, 5500, 0,  0,  40, 20, 1, 40, 0};  // ramp, gap-free
        vecs[4] = '{3, 4600, 5500, 1,  0,  40, 20, 1, 40, 0};  // same ramp with gaps
        vecs[5] = '{0, 5000, 4800, 0,  1,  10, 0,  1, 10, 0};  // start ignored in RUN

        rst          = 1'b1;
        bus.start    = 1'b0;
        bus.ref_rise = '0;
        bus.ref_fall = '0;
        bus.in_valid = 1'b0;
        bus.in_rise  = '0;
        bus.in_fall  = '0;
        repeat (3) @(posedge clk);
        #1;
        check_reset_values("reset");
        rst = 1'b0;

        // in_valid while IDLE must not be taken
        bus.in_valid = 1'b1;
        @(negedge clk);
        check("idle in_ready", 64'(bus.in_ready), 64'd0);
        @(posedge clk); #1;
        bus.in_valid = 1'b0;
        check("idle busy", 64'(bus.busy), 64'd0);

        // Vectors run back to back: each start lands in the cycle after the previous done
        for (int i = 0; i < 6; i++) begin
            run_sweep($sformatf("v%0d", i), vecs[i]);
        end

        // Results hold in IDLE while stray samples arrive
        bus.in_valid = 1'b1;
        repeat (4) @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
        check("hold best_idx", 64'(bus.best_idx), 64'd10);
        check("hold cross_idx", 64'(bus.cross_idx), 64'd10);

        // Reset after 37 accepts discards the partial sweep
        bus.start    = 1'b1;
        bus.ref_rise = delay_t'(5000);
        bus.ref_fall = delay_t'(4800);
        @(posedge clk); #1;
        bus.start = 1'b0;
        k = 0;
        for (int c = 0; c < 200 && k < 37; c++) begin
            sample(0, k, r, f);
            bus.in_rise  = r;
            bus.in_fall  = f;
            bus.in_valid = 1'b1;
            @(negedge clk);
            if (bus.in_valid && bus.in_ready) k++;
            @(posedge clk); #1;
        end
        check("mid accepts", 64'(k), 64'd37);
        check("mid best_idx before rst", 64'(bus.best_idx), 64'd10);
        bus.in_valid = 1'b0;
        rst          = 1'b1;
        @(posedge clk); #1;
        check_reset_values("mid-rst");
        rst      = 1'b0;
        saw_done = 1'b0;
        for (int c = 0; c < 6; c++) begin
            @(posedge clk); #1;
            if (bus.done) saw_done = 1'b1;
        end
        check("mid no done", 64'(saw_done), 64'd0);
        check("mid still idle", 64'(bus.busy), 64'd0);
        vr = vecs[0];
        run_sweep("after-rst", vr);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

    // Global watchdog
    initial begin
        #500000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "timeout");
    end

endmodule
